instruction_fetch_unit: RTL and testbench

Fetch stage of the MIPS pipeline. Holds the program counter, issues single-outstanding word reads to instruction memory, and delivers each fetched instruction with its PC+4 into a one-entry IF/ID buffer. The decode stage consumes that buffer over a valid/ready handshake. Branch and jump redirects from decode are resolved here: the unit computes the target, discards stale fetches, and refetches from the new PC.

---
 rtl/mips_fetch_pkg.sv | 13 +
 rtl/next_pc_gen.sv | 24 ++
 rtl/instruction_fetch_unit.sv | 114 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the MIPS fetch stage
package mips_fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int JIDX_W  = 26;
   localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic {
      REQ  = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/next_pc_gen.sv
// rtl/next_pc_gen.sv - branch/jump target computation and redirect select
module next_pc_gen
   import mips_fetch_pkg::*;
(
   input  logic               branch,
   input  logic               jump,
   input  logic [INSTR_W-1:0] branch_base,
   input  logic [INSTR_W-1:0] branch_imm,
   input  logic [JIDX_W-1:0]  jump_index,
   output logic               redirect,
   output logic [INSTR_W-1:0] target
);

   logic [INSTR_W-1:0] branch_target;
   logic [INSTR_W-1:0] jump_target;

   assign branch_target = branch_base + {branch_imm[29:0], 2'b00};
   assign jump_target   = {branch_base[31:28], jump_index, 2'b00};

   // Jump has priority when decode raises both in one cycle.
   assign target   = jump ? jump_target : branch_target;
   assign redirect = branch | jump;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, single-outstanding imem fetch and IF/ID buffer
module instruction_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
)
(
   input  logic               Clk,
   input  logic               ResetN,
   output logic               ImemReq,
   output logic [INSTR_W-1:0] ImemAddr,
   input  logic               ImemReady,
   input  logic               ImemRspValid,
   input  logic [INSTR_W-1:0] ImemRspData,
   input  logic               Branch,
   input  logic               Jump,
   input  logic [INSTR_W-1:0] BranchBase,
   input  logic [INSTR_W-1:0] BranchImm,
   input  logic [JIDX_W-1:0]  JumpIndex,
   output logic               IfidValid,
   input  logic               IfidReady,
   output logic [INSTR_W-1:0] IfidInstr,
   output logic [INSTR_W-1:0] IfidPCplus4
);

   fetch_state_t       state, state_nxt;
   logic [INSTR_W-1:0] pc, pc_nxt;
   logic [INSTR_W-1:0] req_pc, req_pc_nxt;
   logic               kill, kill_nxt;
   logic               valid_nxt;
   logic [INSTR_W-1:0] instr_nxt, pc4_nxt;
   logic               redirect;
   logic [INSTR_W-1:0] target;
   logic               accept;

   next_pc_gen u_next_pc_gen (
      .branch      (Branch),
      .jump        (Jump),
      .branch_base (BranchBase),
      .branch_imm  (BranchImm),
      .jump_index  (JumpIndex),
      .redirect    (redirect),
      .target      (target)
   );

   // Only request into a buffer that is empty or draining this cycle.
   assign ImemReq  = ResetN && (state == REQ) && (!IfidValid || IfidReady);
   assign ImemAddr = pc;
   assign accept   = ImemReq && ImemReady;

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      req_pc_nxt = req_pc;
      kill_nxt   = kill;
      valid_nxt  = IfidValid;
      instr_nxt  = IfidInstr;
      pc4_nxt    = IfidPCplus4;

      if (IfidValid && IfidReady) valid_nxt = 1'b0;

      case (state)
         REQ: begin
            if (accept) begin
               req_pc_nxt = pc;
               pc_nxt     = pc + 32'd4;
               state_nxt  = WAIT;
               kill_nxt   = redirect;
            end
         end
         WAIT: begin
            if (ImemRspValid) begin
               state_nxt = REQ;
               kill_nxt  = 1'b0;
               if (!kill && !redirect) begin
                  valid_nxt = 1'b1;
                  instr_nxt = ImemRspData;
                  pc4_nxt   = req_pc + 32'd4;
               end
            end else if (redirect) begin
               kill_nxt = 1'b1;
            end
         end
         default: state_nxt = REQ;
      endcase

      // A redirect flushes the buffer and wins over any sequential PC update.
      if (redirect) begin
         pc_nxt    = target;
         valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state       <= REQ;
         pc          <= RESET_PC;
         req_pc      <= '0;
         kill        <= 1'b0;
         IfidValid   <= 1'b0;
         IfidInstr   <= '0;
         IfidPCplus4 <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         req_pc      <= req_pc_nxt;
         kill        <= kill_nxt;
         IfidValid   <= valid_nxt;
         IfidInstr   <= instr_nxt;
         IfidPCplus4 <= pc4_nxt;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

   logic        Clk;
   logic        ResetN0, ResetN1;
   logic        ImemReady, ImemRspValid, IfidReady;
   logic [31:0] ImemRspData;
   logic        Branch, Jump;
   logic [31:0] BranchBase, BranchImm;
   logic [25:0] JumpIndex;

   logic        req0, req1, valid0, valid1;
   logic [31:0] addr0, addr1, instr0, instr1, pc40, pc41;

   int checks = 0;
   int errors = 0;
   logic auto_rsp;

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
      .Clk(Clk), .ResetN(ResetN0), .ImemReq(req0), .ImemAddr(addr0),
      .ImemReady(ImemReady), .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
      .Branch(Branch), .Jump(Jump), .BranchBase(BranchBase), .BranchImm(BranchImm),
      .JumpIndex(JumpIndex), .IfidValid(valid0), .IfidReady(IfidReady),
      .IfidInstr(instr0), .IfidPCplus4(pc40)
   );

   instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
      .Clk(Clk), .ResetN(ResetN1), .ImemReq(req1), .ImemAddr(addr1),
      .ImemReady(ImemReady), .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
      .Branch(Branch), .Jump(Jump), .BranchBase(BranchBase), .BranchImm(BranchImm),
      .JumpIndex(JumpIndex), .IfidValid(valid1), .IfidReady(IfidReady),
      .IfidInstr(instr1), .IfidPCplus4(pc41)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; the optional memory model answers dut0 one cycle after acceptance.
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      #1;
      acc = req0 && ImemReady;
      a   = addr0;
      @(posedge Clk);
      #1;
      Branch = 1'b0;
      Jump   = 1'b0;
      if (auto_rsp) begin
         ImemRspValid = acc;
         ImemRspData  = acc ? (a ^ 32'hDEAD_0000) : 32'h0;
      end
      #1;
   endtask

   initial begin
      ResetN0 = 1'b0; ResetN1 = 1'b0;
      ImemReady = 1'b1; ImemRspValid = 1'b0; ImemRspData = 32'h0;
      IfidReady = 1'b1; Branch = 1'b0; Jump = 1'b0;
      BranchBase = 32'h0; BranchImm = 32'h0; JumpIndex = 26'h0;
      auto_rsp = 1'b1;

      repeat (2) @(posedge Clk);
      #1;
      chk("rst_req", 32'(req0), 32'h0);
      chk("rst_addr", addr0, 32'h0);
      chk("rst_valid", 32'(valid0), 32'h0);
      chk("rst_instr", instr0, 32'h0);
      chk("rst_pc4", pc40, 32'h0);

      // Free run from PC 0 with single-cycle memory.
      ResetN0 = 1'b1;
      #1;
      chk("run_req0", 32'(req0), 32'h1);
      tick();
      chk("run_wait_req", 32'(req0), 32'h0);
      tick();
      chk("run_instr0", instr0, 32'hDEAD_0000);
      chk("run_pc4_0", pc40, 32'h4);
      chk("run_valid0", 32'(valid0), 32'h1);
      chk("run_addr4", addr0, 32'h4);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("run_drained", 32'(valid0), 32'h0);
         tick();
         chk("run_instr", instr0, 32'hDEAD_0000 | 32'(4 * k));
         chk("run_pc4", pc40, 32'(4 * k + 4));
      end

      // Backpressure: buffer full holding the word from 0xC.
      IfidReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_req", 32'(req0), 32'h0);
         tick();
         chk("bp_instr", instr0, 32'hDEAD_000C);
         chk("bp_valid", 32'(valid0), 32'h1);
      end
      chk("bp_addr", addr0, 32'h10);
      IfidReady = 1'b1;
      #1;
      chk("bp_resume_req", 32'(req0), 32'h1);
      tick();
      tick();
      chk("bp_resume_instr", instr0, 32'hDEAD_0010);
      chk("bp_resume_pc4", pc40, 32'h14);

      // Branch while waiting on a slow response.
      auto_rsp = 1'b0;
      tick();
      Branch = 1'b1; BranchBase = 32'h0000_0100; BranchImm = 32'hFFFF_FFFE;
      tick();
      chk("br_valid", 32'(valid0), 32'h0);
      chk("br_wait_req", 32'(req0), 32'h0);
      chk("br_pc", addr0, 32'h0000_00F8);
      ImemRspValid = 1'b1; ImemRspData = 32'h1234_5678;
      tick();
      ImemRspValid = 1'b0;
      chk("br_killed_valid", 32'(valid0), 32'h0);
      chk("br_refetch_req", 32'(req0), 32'h1);
      chk("br_refetch_addr", addr0, 32'h0000_00F8);
      auto_rsp = 1'b1;
      tick();
      chk("br_pending_valid", 32'(valid0), 32'h0);
      tick();
      chk("br_instr", instr0, 32'hDEAD_00F8);
      chk("br_pc4", pc40, 32'h0000_00FC);

      // Jump and branch together, raised while a request is accepted.
      Branch = 1'b1; Jump = 1'b1;
      BranchBase = 32'h9000_0010; BranchImm = 32'h0000_0004; JumpIndex = 26'h000_0040;
      tick();
      chk("jmp_pc", addr0, 32'h9000_0100);
      chk("jmp_flush", 32'(valid0), 32'h0);
      tick();
      chk("jmp_stale_dropped", 32'(valid0), 32'h0);
      chk("jmp_refetch_req", 32'(req0), 32'h1);
      tick();
      tick();
      chk("jmp_instr", instr0, 32'h4EAD_0100);
      chk("jmp_pc4", pc40, 32'h9000_0104);

      // Redirect in the same cycle the response returns.
      tick();
      Branch = 1'b1; BranchBase = 32'h0000_0200; BranchImm = 32'h0000_0010;
      tick();
      chk("co_valid", 32'(valid0), 32'h0);
      chk("co_req", 32'(req0), 32'h1);
      chk("co_addr", addr0, 32'h0000_0240);
      tick();
      tick();
      chk("co_instr", instr0, 32'hDEAD_0240);
      chk("co_pc4", pc40, 32'h0000_0244);

      // Wrap from the top of the address space, then async reset mid-WAIT.
      auto_rsp = 1'b0;
      ImemRspValid = 1'b0;
      ResetN0 = 1'b0;
      #1;
      chk("async0_req", 32'(req0), 32'h0);
      chk("async0_valid", 32'(valid0), 32'h0);
      chk("wrap_rst_addr", addr1, 32'hFFFF_FFFC);
      chk("wrap_rst_req", 32'(req1), 32'h0);
      ResetN1 = 1'b1;
      #1;
      chk("wrap_req", 32'(req1), 32'h1);
      tick();
      ImemRspValid = 1'b1; ImemRspData = 32'hAAAA_5555;
      tick();
      ImemRspValid = 1'b0;
      chk("wrap_instr", instr1, 32'hAAAA_5555);
      chk("wrap_pc4", pc41, 32'h0000_0000);
      chk("wrap_addr", addr1, 32'h0000_0000);
      tick();
      chk("wrap_wait_req", 32'(req1), 32'h0);
      chk("wrap_next_addr", addr1, 32'h0000_0004);
      #2;
      ResetN1 = 1'b0;
      #1;
      chk("async1_req", 32'(req1), 32'h0);
      chk("async1_valid", 32'(valid1), 32'h0);
      chk("async1_addr", addr1, 32'hFFFF_FFFC);
      chk("async1_instr", instr1, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
